// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache with a single-outstanding line refill.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_responder #(
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        icache_REN,
  input  logic [31:0] icache_addr,
  input  logic        icache_halt,
  output logic        icache_hit,
  output logic [31:0] icache_load,
  output logic        icache_halted,
  output logic        mem_REN,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_load,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int WB = $clog2(BLOCK_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int CW = (WB > 0) ? WB : 1;
  localparam int TW = 30 - WB - IB;

  // state    | meaning
  // S_IDLE   | serving lookups, hits answered combinationally
  // S_FILL   | refilling fill_idx word by word from memory
  // S_HALTED | frozen until reset
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]    state;
  logic [SETS-1:0] valid;
  logic [TW-1:0] tags [SETS];
  logic [31:0]   data [SETS][BLOCK_WORDS];

  logic [TW-1:0] fill_tag;
  logic [IB-1:0] fill_idx;
  logic [CW-1:0] cnt;

  logic [TW-1:0] req_tag;
  logic [IB-1:0] req_idx;
  logic [CW-1:0] req_word;
  logic          lookup_hit;
  logic          miss;
  logic          last_word;
  logic          fill_beat;

  assign req_word = CW'((icache_addr >> 2) & 32'(BLOCK_WORDS - 1));
  assign req_idx  = IB'(icache_addr >> (2 + WB));
  assign req_tag  = TW'(icache_addr >> (2 + WB + IB));

  assign lookup_hit = (state == S_IDLE) && icache_REN && valid[req_idx] &&
                      (tags[req_idx] == req_tag);
  assign miss       = (state == S_IDLE) && icache_REN && !lookup_hit;
  assign last_word  = (cnt == CW'(BLOCK_WORDS - 1));
  // A halt in the same cycle as a beat wins, so the beat is dropped entirely.
  assign fill_beat  = (state == S_FILL) && mem_ready && !icache_halt;

  assign icache_hit    = lookup_hit;
  assign icache_load   = lookup_hit ? data[req_idx][req_word] : 32'd0;
  assign icache_halted = (state == S_HALTED);
  assign mem_REN       = (state == S_FILL);
  assign mem_addr      = (state == S_FILL) ?
                         ((32'(fill_tag) << (2 + WB + IB)) |
                          (32'(fill_idx) << (2 + WB)) |
                          (32'(cnt) << 2)) : 32'd0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      valid    <= '0;
      cnt      <= '0;
      fill_tag <= '0;
      fill_idx <= '0;
    end else if (icache_halt) begin
      state <= S_HALTED;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss) begin
            state          <= S_FILL;
            fill_tag       <= req_tag;
            fill_idx       <= req_idx;
            valid[req_idx] <= 1'b0;
            cnt            <= '0;
          end
        end
        S_FILL: begin
          if (mem_ready) begin
            cnt <= cnt + CW'(1);
            if (last_word) begin
              valid[fill_idx] <= 1'b1;
              state           <= S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && fill_beat) begin
      data[fill_idx][cnt] <= mem_load;
      if (last_word) tags[fill_idx] <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_q  <= 32'd0;
      miss_q <= 32'd0;
    end else begin
      if (icache_REN && lookup_hit) hit_q <= hit_q + 32'd1;
      if (miss && !icache_halt) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule
